// File: rtl/demux_scheduler.sv
// demux_scheduler
//   Holds one upstream word at a time and offers it to one of eight sink
//   channels. The channel is picked either round-robin over the enabled
//   channels or fixed by cfg_sel. A word that no sink takes within TIMEOUT
//   cycles is dropped, and drop pulses for one cycle.
//
// State table
//   state | meaning
//   IDLE  | no word held; in_ready is high when a valid target exists
//   HOLD  | word held in dst_data and offered on dst_valid[sel]
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   upstream word available
//   in_data    upstream word (WIDTH bits)
//   in_ready   block accepts a word this cycle
//   mode       0 = round-robin routing, 1 = fixed routing to cfg_sel
//   cfg_sel    destination channel in fixed mode
//   chan_en    per-channel enable mask
//   dst_ready  per-channel sink ready; only bit sel is looked at
//   dst_valid  one-hot offer to channel sel while a word is held
//   dst_data   held word, shared by all channels
//   sel        current or last target channel
//   drop       one-cycle pulse when a held word times out
//   xfer_cnt   count of completed transfers, wraps at 16 bits
module demux_scheduler #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             mode,
  input  logic [2:0]       cfg_sel,
  input  logic [7:0]       chan_en,
  input  logic [7:0]       dst_ready,
  output logic [7:0]       dst_valid,
  output logic [WIDTH-1:0] dst_data,
  output logic [2:0]       sel,
  output logic             drop,
  output logic [15:0]      xfer_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Last HOLD cycle before a word is discarded; the counter starts at 0.
  localparam logic [7:0] TC_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [2:0] ptr;
  logic [7:0] tcnt;

  logic [2:0] rr_idx;
  logic [2:0] rr_tgt;
  logic       rr_found;
  logic [2:0] tgt;
  logic       tgt_ok;
  logic       accept;
  logic       xfer;
  logic       expire;

  // Round-robin search starting at ptr. The loop walks the offsets from the
  // farthest to the nearest, so the nearest enabled channel is the one left
  // in rr_tgt. The 3-bit index wraps from 7 to 0 on its own.
  always_comb begin
    rr_idx   = ptr;
    rr_tgt   = ptr;
    rr_found = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      rr_idx = ptr + 3'(k);
      if (chan_en[rr_idx]) begin
        rr_tgt   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    tgt    = mode ? cfg_sel : rr_tgt;
    tgt_ok = mode ? chan_en[cfg_sel] : rr_found;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    dst_valid = 8'h00;
    accept    = 1'b0;
    xfer      = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        // in_ready is gated by rst so it reads low for the whole reset.
        in_ready = tgt_ok & ~rst;
        accept   = in_valid & in_ready;
        if (accept) state_nxt = HOLD;
      end
      HOLD: begin
        dst_valid = 8'h01 << sel;
        xfer      = dst_ready[sel];
        // A transfer in the last cycle takes priority over the timeout.
        expire    = ~xfer && (tcnt == TC_LAST);
        if (xfer || expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 3'd0;
      sel      <= 3'd0;
      dst_data <= '0;
      tcnt     <= 8'd0;
      drop     <= 1'b0;
      xfer_cnt <= 16'd0;
    end else begin
      drop <= expire;
      if (accept) begin
        dst_data <= in_data;
        sel      <= tgt;
        tcnt     <= 8'd0;
      end
      if (state == HOLD && !xfer && !expire) tcnt <= tcnt + 8'd1;
      // The pointer moves past the last target whether it was taken or dropped.
      if (xfer || expire) ptr <= sel + 3'd1;
      if (xfer) xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_demux_scheduler.sv
module tb_demux_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mode = 1'b0;
  logic [2:0]  cfg_sel = 3'd0;
  logic [7:0]  chan_en = 8'hFF;
  logic [7:0]  dst_ready = 8'h00;
  logic [7:0]  dst_valid;
  logic [7:0]  dst_data;
  logic [2:0]  sel;
  logic        drop;
  logic [15:0] xfer_cnt;

  int tests = 0;
  int fails = 0;
  int drop_cnt = 0;

  demux_scheduler #(.WIDTH(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mode(mode), .cfg_sel(cfg_sel), .chan_en(chan_en),
    .dst_ready(dst_ready), .dst_valid(dst_valid), .dst_data(dst_data),
    .sel(sel), .drop(drop), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (drop === 1'b1) drop_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       mode;
    logic [2:0] cfg;
    logic [7:0] en;
    logic [7:0] data;
    logic [2:0] exp_sel;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a word and return right after the accepting rising edge, so the
  // caller's next negedge is the first HOLD cycle.
  task automatic send(input logic m, input logic [2:0] c, input logic [7:0] en,
                      input logic [7:0] d);
    int n;
    @(negedge clk);
    mode = m; cfg_sel = c; chan_en = en; in_data = d; in_valid = 1'b1;
    #1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (in_ready !== 1'b1) chk("accept_wait", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // One word through with all sinks ready: one HOLD cycle then back to IDLE.
  task automatic do_word(input string name, input logic m, input logic [2:0] c,
                         input logic [7:0] en, input logic [7:0] d,
                         input logic [2:0] exp_sel, input logic [15:0] exp_cnt);
    dst_ready = 8'hFF;
    send(m, c, en, d);
    @(negedge clk);
    chk({name, "_sel"}, sel, exp_sel);
    chk({name, "_valid"}, dst_valid, 8'h01 << exp_sel);
    chk({name, "_data"}, dst_data, d);
    @(negedge clk);
    chk({name, "_idle"}, dst_valid, 8'h00);
    chk({name, "_cnt"}, xfer_cnt, exp_cnt);
  endtask

  initial begin
    int bad;
    int drops_before;

    for (int i = 0; i < 10; i++) vecs[i] = '{1'b0, 3'd0, 8'hFF, 8'(i), 3'(i % 8)};
    vecs[10] = '{1'b0, 3'd0, 8'h24, 8'h10, 3'd2};
    vecs[11] = '{1'b0, 3'd0, 8'h24, 8'h11, 3'd5};
    vecs[12] = '{1'b0, 3'd0, 8'h24, 8'h12, 3'd2};
    vecs[13] = '{1'b0, 3'd0, 8'h24, 8'h13, 3'd5};
    vecs[14] = '{1'b1, 3'd3, 8'hFF, 8'hC3, 3'd3};
    vecs[15] = '{1'b1, 3'd7, 8'h80, 8'hC7, 3'd7};
    vecs[16] = '{1'b0, 3'd5, 8'h01, 8'hE0, 3'd0};
    vecs[17] = '{1'b0, 3'd0, 8'h80, 8'hE7, 3'd7};

    // Reset values, with a would-be word waiting upstream.
    in_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_dst_valid", dst_valid, 0);
    chk("rst_sel", sel, 0);
    chk("rst_dst_data", dst_data, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    chk("rst_drop", drop, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Round-robin order, skip mask, fixed mode, wrap through channel 7.
    for (int i = 0; i < 18; i++)
      do_word($sformatf("vec%0d", i), vecs[i].mode, vecs[i].cfg, vecs[i].en,
              vecs[i].data, vecs[i].exp_sel, 16'(i + 1));
    chk("vec_no_drop", drop_cnt, 0);

    // Empty mask, and fixed mode onto a disabled channel.
    @(negedge clk);
    mode = 1'b0; chan_en = 8'h00; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0) bad++;
    end
    chk("empty_mask_ready", bad, 0);
    mode = 1'b1; cfg_sel = 3'd2; chan_en = 8'hFB;
    #1;
    chk("fixed_disabled_ready", in_ready, 0);
    in_valid = 1'b0;

    // Fixed mode stall on channel 6; channel 3 ready is ignored, config
    // changes during HOLD do not disturb the held word.
    dst_ready = 8'h08;
    send(1'b1, 3'd6, 8'hFF, 8'h66);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("stall_valid%0d", i), dst_valid, 8'h40);
      chk($sformatf("stall_data%0d", i), dst_data, 8'h66);
      if (i == 0) begin chan_en = 8'h00; mode = 1'b0; cfg_sel = 3'd1; end
      if (i == 5) dst_ready = 8'h48;
    end
    @(negedge clk);
    chk("stall_idle", dst_valid, 8'h00);
    chk("stall_cnt", xfer_cnt, 19);
    chk("stall_sel_kept", sel, 6);
    chk("stall_data_kept", dst_data, 8'h66);

    // Timeout: ptr is 7 after the stall transfer.
    dst_ready = 8'h00;
    drops_before = drop_cnt;
    send(1'b0, 3'd0, 8'hFF, 8'hA5);
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (dst_valid !== 8'h80 || drop !== 1'b0) bad++;
    end
    chk("to_hold_15", bad, 0);
    @(negedge clk);
    chk("to_drop", drop, 1);
    chk("to_idle", dst_valid, 8'h00);
    chk("to_cnt", xfer_cnt, 19);
    @(negedge clk);
    chk("to_drop_clear", drop, 0);
    chk("to_drop_once", drop_cnt - drops_before, 1);

    // Transfer in the timeout cycle wins; next word goes to sel+1 = 0.
    send(1'b0, 3'd0, 8'hFF, 8'h5A);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) chk("tw_sel", sel, 0);
      if (k == 15) dst_ready = 8'h01;
    end
    @(negedge clk);
    chk("tw_no_drop", drop, 0);
    chk("tw_idle", dst_valid, 8'h00);
    chk("tw_cnt", xfer_cnt, 20);
    dst_ready = 8'h00;

    // Reset in the middle of HOLD on channel 3.
    drops_before = drop_cnt;
    send(1'b1, 3'd3, 8'hFF, 8'h33);
    @(negedge clk);
    chk("rh_valid", dst_valid, 8'h08);
    in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rh_valid_clr", dst_valid, 8'h00);
    chk("rh_sel", sel, 0);
    chk("rh_cnt", xfer_cnt, 0);
    chk("rh_drop", drop, 0);
    chk("rh_in_ready", in_ready, 0);
    @(negedge clk); @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rh_no_drop", drop_cnt - drops_before, 0);
    do_word("rh_next", 1'b0, 3'd0, 8'hFF, 8'h44, 3'd0, 16'd1);

    // Counter wrap from a preloaded near-full value.
    @(negedge clk);
    force dut.xfer_cnt = 16'hFFFE;
    #1;
    release dut.xfer_cnt;
    #1;
    chk("wrap_preload", xfer_cnt, 16'hFFFE);
    do_word("wrap_a", 1'b0, 3'd0, 8'hFF, 8'h77, 3'd1, 16'hFFFF);
    do_word("wrap_b", 1'b0, 3'd0, 8'hFF, 8'h78, 3'd2, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
